// File: rtl/packet_assembler_pkg.sv
// Shared definitions for the packet assembler: flit format,
// flit type encodings and packet slot states.
package packet_assembler_pkg;

  localparam int FLIT_WIDTH = 32;
  localparam int MAX_PACKET_LENGHT = 5;
  localparam int N_SLOTS = 2;
  localparam int N_BITS_FLIT_CNT = 3;

  localparam int FLIT_TYPE_HI = FLIT_WIDTH - 1;
  localparam int FLIT_TYPE_LO = FLIT_WIDTH - 2;
  localparam int LINK_WIDTH = MAX_PACKET_LENGHT * FLIT_WIDTH;

  typedef logic [FLIT_WIDTH-1:0] flit_t;
  typedef logic [N_BITS_FLIT_CNT-1:0] cnt_t;
  typedef logic [1:0] flit_type_t;

  localparam flit_type_t BODY_FLIT = 2'b00;
  localparam flit_type_t HEAD_FLIT = 2'b01;
  localparam flit_type_t HEAD_TAIL_FLIT = 2'b10;
  localparam flit_type_t TAIL_FLIT = 2'b11;

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_FILLING = 2'd1,
    SLOT_FULL = 2'd2
  } slot_state_e;

  function automatic flit_type_t flit_type(input flit_t f);
    return f[FLIT_TYPE_HI:FLIT_TYPE_LO];
  endfunction

endpackage

// File: rtl/packet_assembler_slot.sv
// One packet slot: flit storage, valid mask, flit count
// and the EMPTY -> FILLING -> FULL -> EMPTY state machine.
module packet_slot
  import packet_assembler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic wr,
  input  logic last,
  input  logic clr,
  input  flit_t flit,
  output slot_state_e state,
  output cnt_t count,
  output logic [LINK_WIDTH-1:0] link,
  output logic [MAX_PACKET_LENGHT-1:0] sel
);

  cnt_t idx;

  // A fresh packet always starts at index 0.
  assign idx = (state == SLOT_EMPTY) ? '0 : count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= SLOT_EMPTY;
      count <= '0;
      link <= '0;
      sel <= '0;
    end else if (wr && state != SLOT_FULL) begin
      link[int'(idx)*FLIT_WIDTH +: FLIT_WIDTH] <= flit;
      sel[idx] <= 1'b1;
      count <= idx + cnt_t'(1);
      state <= last ? SLOT_FULL : SLOT_FILLING;
    end
  end

endmodule

// File: rtl/packet_assembler.sv
// Reassembles NoC flits into packets in two ping-pong slots
// and offers each full packet to message_queue by req/grant.
module packet_assembler
  import packet_assembler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic [FLIT_WIDTH-1:0] flit_i,
  input  logic flit_valid_i,
  output logic flit_ready_o,
  output logic [LINK_WIDTH-1:0] out_link_o,
  output logic [MAX_PACKET_LENGHT-1:0] out_sel_o,
  output logic r_pkt_to_msg_o,
  input  logic g_pkt_to_msg_i,
  output logic error_o
);

  logic wp;
  logic rp;
  slot_state_e state [N_SLOTS];
  cnt_t count [N_SLOTS];
  logic [LINK_WIDTH-1:0] link [N_SLOTS];
  logic [MAX_PACKET_LENGHT-1:0] sel [N_SLOTS];
  logic [N_SLOTS-1:0] wr;
  logic [N_SLOTS-1:0] clr;

  logic xfer;
  logic w_empty;
  logic store;
  logic last;
  logic drop;
  logic ovf;
  logic grant;
  logic rd_full;
  flit_type_t ftype;

  assign flit_ready_o = (state[wp] != SLOT_FULL);
  assign xfer = flit_valid_i && flit_ready_o;
  assign ftype = flit_type(flit_i);
  assign w_empty = (state[wp] == SLOT_EMPTY);
  assign grant = g_pkt_to_msg_i && r_pkt_to_msg_o;
  assign rd_full = (state[rp] == SLOT_FULL);

  always_comb begin
    store = 1'b0;
    last = 1'b0;
    drop = 1'b0;
    ovf = 1'b0;
    if (xfer) begin
      unique case (1'b1)
        w_empty && ftype == HEAD_TAIL_FLIT: begin
          store = 1'b1;
          last = 1'b1;
        end
        w_empty && ftype == HEAD_FLIT: begin
          store = 1'b1;
        end
        !w_empty && ftype == BODY_FLIT: begin
          store = 1'b1;
          ovf = count[wp] == cnt_t'(MAX_PACKET_LENGHT-1);
          last = ovf;
        end
        !w_empty && ftype == TAIL_FLIT: begin
          store = 1'b1;
          last = 1'b1;
        end
        default: begin
          drop = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    wr = '0;
    clr = '0;
    wr[wp] = store;
    clr[rp] = grant;
  end

  for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
    packet_slot u_slot (
      .clk(clk),
      .rst(rst),
      .wr(wr[i]),
      .last(last),
      .clr(clr[i]),
      .flit(flit_i),
      .state(state[i]),
      .count(count[i]),
      .link(link[i]),
      .sel(sel[i])
    );
  end

  // Request drops on the grant edge so it is low at least one
  // cycle before the next full slot is offered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= 1'b0;
      rp <= 1'b0;
      r_pkt_to_msg_o <= 1'b0;
      error_o <= 1'b0;
    end else begin
      if (store && last) wp <= ~wp;
      if (grant) rp <= ~rp;
      r_pkt_to_msg_o <= !grant && rd_full;
      error_o <= drop || ovf;
    end
  end

  assign out_link_o = rd_full ? link[rp] : '0;
  assign out_sel_o = rd_full ? sel[rp] : '0;

endmodule

// File: tb/tb_packet_assembler.sv
// Scoreboard bench for packet_assembler: flit-level reference
// model feeds an expected-packet queue drained by a grant monitor.
module tb_packet_assembler;

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_HT = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b11;
  localparam int MPL = 5;

  typedef struct {
    logic [159:0] link;
    logic [4:0] sel;
  } pkt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flit_valid = 1'b0;
  logic g = 1'b0;
  logic [31:0] flit = '0;
  logic ready;
  logic req;
  logic err;
  logic [159:0] out_link;
  logic [4:0] out_sel;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int err_exp = 0;
  int completed = 0;
  int grants = 0;
  int hold = 1;
  bit in_prog = 1'b0;
  logic [31:0] cur[$];
  pkt_t exp_q[$];

  always #5 clk = ~clk;

  packet_assembler dut (
    .clk(clk),
    .rst(rst),
    .flit_i(flit),
    .flit_valid_i(flit_valid),
    .flit_ready_o(ready),
    .out_link_o(out_link),
    .out_sel_o(out_sel),
    .r_pkt_to_msg_o(req),
    .g_pkt_to_msg_i(g),
    .error_o(err)
  );

  always @(posedge clk)
    if (!rst && g && req) grants <= grants + 1;

  task automatic chk(input string name,
                     input logic [159:0] act,
                     input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic emit();
    pkt_t p;
    p.link = '0;
    p.sel = '0;
    foreach (cur[k]) begin
      p.link[k*32 +: 32] = cur[k];
      p.sel[k] = 1'b1;
    end
    exp_q.push_back(p);
    completed++;
    cur.delete();
    in_prog = 1'b0;
  endtask

  // Packet-level rules: a packet opens with HEAD, grows with BODY,
  // closes with TAIL or at MPL flits; anything else is a violation.
  task automatic model(input logic [31:0] f);
    logic [1:0] t;
    t = f[31:30];
    if (!in_prog) begin
      if (t == T_HT) begin
        cur.push_back(f);
        emit();
      end else if (t == T_HEAD) begin
        cur.push_back(f);
        in_prog = 1'b1;
      end else err_exp++;
    end else begin
      if (t == T_BODY) begin
        cur.push_back(f);
        if (cur.size() == MPL) begin
          emit();
          err_exp++;
        end
      end else if (t == T_TAIL) begin
        cur.push_back(f);
        emit();
      end else err_exp++;
    end
  endtask

  task automatic send(input logic [1:0] t, input logic [29:0] pay);
    int tries = 0;
    bit go;
    flit = {t, pay};
    flit_valid = 1'b1;
    forever begin
      go = (completed - grants) < 2;
      chk("flit_ready", {159'b0, ready}, {159'b0, go});
      @(posedge clk);
      if (go) begin
        model(flit);
        break;
      end
      tries++;
      if (tries > 200) begin
        checks++;
        errors++;
        $display("FAIL stall_timeout: ready %0b after %0d cycles", ready, tries);
        break;
      end
      #1;
    end
    #1;
    flit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || req) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d packets left", exp_q.size());
    end
    repeat (3) @(negedge clk);
    chk("error_count", err_seen, err_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic send3();
    send(T_HEAD, 30'($urandom));
    send(T_BODY, 30'($urandom));
    send(T_TAIL, 30'($urandom));
  endtask

  initial begin : monitor
    int cnt;
    int low;
    bit was;
    bit granted;
    bit b2b;
    cnt = 0;
    low = 0;
    was = 1'b0;
    granted = 1'b0;
    b2b = 1'b0;
    forever begin
      @(negedge clk);
      g = 1'b0;
      if (err) err_seen++;
      if (rst) begin
        was = 1'b0;
        granted = 1'b0;
        b2b = 1'b0;
        cnt = 0;
      end else begin
        if (granted) begin
          chk("req_after_grant", {159'b0, req}, 160'b0);
          chk("sel_after_grant", {155'b0, out_sel},
              {155'b0, exp_q.size() != 0 ? exp_q[0].sel : 5'b0});
          granted = 1'b0;
        end
        if (req) begin
          if (!was) begin
            cnt = 0;
            if (b2b) chk("b2b_gap", low, 1);
            b2b = 1'b0;
          end
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_req: sel %0h", out_sel);
          end else begin
            chk("pkt_sel", {155'b0, out_sel}, {155'b0, exp_q[0].sel});
            chk("pkt_link", out_link, exp_q[0].link);
            if (cnt >= hold) begin
              g = 1'b1;
              void'(exp_q.pop_front());
              granted = 1'b1;
              b2b = exp_q.size() != 0;
              low = 0;
            end
            cnt++;
          end
        end else low++;
        was = req;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req", {159'b0, req}, 160'b0);
    chk("rst_err", {159'b0, err}, 160'b0);
    chk("rst_sel", {155'b0, out_sel}, 160'b0);
    chk("rst_link", out_link, 160'b0);
    chk("rst_ready", {159'b0, ready}, 160'b1);
    @(posedge clk);
    #1;

    // single HEAD_TAIL and its one-cycle request latency
    send(T_HT, 30'h20000001);
    @(negedge clk);
    chk("lat_req0", {159'b0, req}, 160'b0);
    @(negedge clk);
    chk("lat_req1", {159'b0, req}, 160'b1);
    chk("ht_sel", {155'b0, out_sel}, 160'b1);
    chk("ht_link", out_link, 160'hA0000001);
    wait_idle();

    // three-flit packet, request stays low until the tail
    send(T_HEAD, 30'h0000_1111);
    send(T_BODY, 30'h0000_2222);
    chk("req_before_tail", {159'b0, req}, 160'b0);
    send(T_TAIL, 30'h0000_3333);
    wait_idle();

    // grant withheld: both slots fill, third packet stalls
    hold = 20;
    send3();
    send3();
    send3();
    wait_idle();
    hold = 1;

    // dropped BODY and HEAD during FILLING
    send(T_BODY, 30'h0BAD_0001);
    send(T_HEAD, 30'h0000_0A0A);
    send(T_HEAD, 30'h0BAD_0002);
    send(T_TAIL, 30'h0000_0B0B);
    send(T_HT, 30'h0000_0C0C);
    wait_idle();

    // overflow at MPL flits, trailing BODY dropped
    send(T_HEAD, 30'h1);
    for (int i = 0; i < 5; i++) send(T_BODY, 30'(i + 2));
    wait_idle();

    // reset mid-packet and mid-request
    hold = 40;
    send(T_HT, 30'h0000_5555);
    n = 0;
    while (!req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_req", {159'b0, req}, 160'b1);
    @(posedge clk);
    #1;
    send(T_HEAD, 30'h0000_6666);
    flit = {T_BODY, 30'h0000_7777};
    flit_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    flit_valid = 1'b0;
    exp_q.delete();
    cur.delete();
    in_prog = 1'b0;
    completed = grants;
    @(negedge clk);
    chk("mid_rst_req", {159'b0, req}, 160'b0);
    chk("mid_rst_sel", {155'b0, out_sel}, 160'b0);
    chk("mid_rst_ready", {159'b0, ready}, 160'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hold = 1;
    send(T_HT, 30'h0000_8888);
    wait_idle();

    // randomized traffic with varying grant delay
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [1:0] t;
      if ($urandom_range(0, 19) == 0) hold = $urandom_range(0, 4);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      r = $urandom_range(0, 9);
      if (in_prog)
        t = r < 5 ? T_BODY : r < 8 ? T_TAIL : r < 9 ? T_HEAD : T_HT;
      else
        t = r < 4 ? T_HEAD : r < 8 ? T_HT : r < 9 ? T_BODY : T_TAIL;
      send(t, 30'($urandom));
    end
    if (in_prog) send(T_TAIL, 30'($urandom));
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
